// File: rtl/hatch_if.sv
// hatch_if: command inputs and display/status outputs of the incubation sequencer
interface hatch_if;
  logic start, stop, temp_ok;
  logic [3:0] num;
  logic st, temp, done, fail;
  modport master(output start, stop, temp_ok, input num, st, temp, done, fail);
  modport slave(input start, stop, temp_ok, output num, st, temp, done, fail);
endinterface

// File: rtl/hatch_seq.sv
// hatch_seq: egg incubation stage sequencer driving a dot-matrix stage display
module hatch_seq #(
  parameter int TICKS_PER_STAGE = 1000,
  parameter int LAST_STAGE = 11,
  parameter int GOOD_TICKS = 200,
  parameter int FAIL_TICKS = 5000
) (
  input logic clk,
  input logic rst,
  hatch_if.slave h
);
  typedef enum logic [2:0] {IDLE, RUN, HOLD, DONE, FAIL} state_t;
  state_t state, state_n;
  logic [3:0] num_n;
  logic [15:0] tick, tick_n, good, good_n, hold, hold_n;
  always_comb begin
    state_n = state;
    num_n = h.num;
    tick_n = tick;
    good_n = good;
    hold_n = hold;
    case (state)
      RUN:
        if (!h.temp_ok) begin
          state_n = HOLD;
          good_n = '0;
          hold_n = '0;
        end else if (tick == 16'(TICKS_PER_STAGE - 1)) begin
          tick_n = '0;
          num_n = h.num + 4'd1;
          state_n = (num_n == 4'(LAST_STAGE)) ? DONE : RUN;
        end else tick_n = tick + 16'd1;
      HOLD: begin
        hold_n = hold + 16'd1;
        good_n = h.temp_ok ? good + 16'd1 : '0;
        // a timeout on the same cycle as recovery still fails the batch
        if (hold_n == 16'(FAIL_TICKS)) begin
          state_n = FAIL;
          num_n = 4'd15;
        end else if (good_n == 16'(GOOD_TICKS)) begin
          state_n = RUN;
          good_n = '0;
        end
      end
      IDLE, DONE, FAIL:
        if (h.start) begin
          state_n = RUN;
          num_n = '0;
          tick_n = '0;
          good_n = '0;
          hold_n = '0;
        end
      default: state_n = IDLE;
    endcase
    if (h.stop) begin
      state_n = IDLE;
      num_n = '0;
      tick_n = '0;
      good_n = '0;
      hold_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tick <= '0;
      good <= '0;
      hold <= '0;
      h.num <= '0;
      h.st <= 1'b0;
      h.temp <= 1'b0;
      h.done <= 1'b0;
      h.fail <= 1'b0;
    end else begin
      state <= state_n;
      tick <= tick_n;
      good <= good_n;
      hold <= hold_n;
      h.num <= num_n;
      h.st <= state_n != IDLE;
      h.temp <= state_n == HOLD || state_n == FAIL;
      h.done <= state_n == DONE;
      h.fail <= state_n == FAIL;
    end
endmodule

// File: tb/tb_hatch_seq.sv
// tb_hatch_seq: directed scenarios plus random stimulus against a progress-based model
module tb_hatch_seq;
  localparam int T = 4, LAST = 11, G = 3, F = 20;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3, M_FAIL = 4;
  logic clk, rst;
  hatch_if bus();
  hatch_seq #(.TICKS_PER_STAGE(T), .LAST_STAGE(LAST), .GOOD_TICKS(G), .FAIL_TICKS(F))
    dut (.clk(clk), .rst(rst), .h(bus.slave));
  int tests = 0, fails = 0;
  int m_mode = M_IDLE, prog = 0, hl = 0, gr = 0;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // progress model: total good RUN cycles since start; stage is that divided by T
  always @(posedge clk or posedge rst)
    if (rst || bus.stop) begin
      m_mode = M_IDLE;
      prog = 0;
    end else
      case (m_mode)
        M_RUN:
          if (!bus.temp_ok) begin
            m_mode = M_HOLD;
            hl = 0;
            gr = 0;
          end else begin
            prog++;
            if (prog == LAST * T) m_mode = M_DONE;
          end
        M_HOLD: begin
          hl++;
          gr = bus.temp_ok ? gr + 1 : 0;
          if (hl == F) m_mode = M_FAIL;
          else if (gr == G) m_mode = M_RUN;
        end
        default:
          if (bus.start) begin
            m_mode = M_RUN;
            prog = 0;
          end
      endcase
  function automatic logic [7:0] expv();
    logic [3:0] n;
    n = m_mode == M_FAIL ? 4'd15 : m_mode == M_DONE ? 4'(LAST) : m_mode == M_IDLE ? 4'd0 : 4'(prog / T);
    return {n, m_mode != M_IDLE, m_mode == M_HOLD || m_mode == M_FAIL, m_mode == M_DONE, m_mode == M_FAIL};
  endfunction
  function automatic logic [7:0] outs();
    return {bus.num, bus.st, bus.temp, bus.done, bus.fail};
  endfunction
  always @(negedge clk)
    if (!rst) chk("outputs", 32'(outs()), 32'(expv()));
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_start();
    bus.start = 1;
    tick(1);
    bus.start = 0;
  endtask
  initial begin
    int k, p;
    rst = 1;
    bus.start = 0;
    bus.stop = 0;
    bus.temp_ok = 1;
    tick(3);
    rst = 0;
    chk("reset_state", 32'(outs()), 0);
    tick(3);
    chk("idle_wait", 32'(outs()), 0);
    pulse_start();
    chk("run_entry", 32'({bus.num, bus.st}), 32'({4'd0, 1'b1}));
    k = 0;
    while (!bus.done && k < 100) begin
      tick(1);
      k++;
    end
    chk("done_latency", k, 44);
    chk("done_num", 32'(bus.num), 11);
    pulse_start();
    tick(14);
    chk("pre_hold_num", 32'(bus.num), 3);
    bus.temp_ok = 0;
    tick(5);
    bus.temp_ok = 1;
    chk("hold_temp", 32'({bus.num, bus.temp}), 32'({4'd3, 1'b1}));
    tick(3);
    chk("resume", 32'({bus.num, bus.temp}), 32'({4'd3, 1'b0}));
    tick(1);
    chk("resume_plus1", 32'(bus.num), 3);
    tick(1);
    chk("resume_plus2", 32'(bus.num), 4);
    bus.temp_ok = 0;
    tick(20);
    chk("pre_fail", 32'(bus.fail), 0);
    tick(1);
    chk("fail", 32'({bus.num, bus.fail}), 32'({4'd15, 1'b1}));
    tick(4);
    chk("fail_stays", 32'({bus.num, bus.fail}), 32'({4'd15, 1'b1}));
    bus.temp_ok = 1;
    pulse_start();
    chk("fail_restart", 32'({bus.num, bus.st, bus.fail}), 32'({4'd0, 1'b1, 1'b0}));
    tick(20);
    chk("num5", 32'(bus.num), 5);
    bus.start = 1;
    bus.stop = 1;
    tick(1);
    bus.start = 0;
    bus.stop = 0;
    chk("stop_wins", 32'({bus.num, bus.st}), 0);
    tick(2);
    chk("stop_idle", 32'(outs()), 0);
    pulse_start();
    chk("restart", 32'({bus.num, bus.st}), 32'({4'd0, 1'b1}));
    tick(28);
    chk("num7", 32'(bus.num), 7);
    bus.temp_ok = 0;
    tick(3);
    chk("hold7", 32'({bus.num, bus.temp}), 32'({4'd7, 1'b1}));
    #2 rst = 1;
    #1 chk("async_rst", 32'(outs()), 0);
    #1 rst = 0;
    bus.temp_ok = 1;
    tick(5);
    chk("post_rst_idle", 32'(outs()), 0);
    p = 90;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) p = $urandom_range(0, 2) == 0 ? 5 : $urandom_range(0, 1) ? 50 : 97;
      bus.start = $urandom_range(0, 99) < 3;
      bus.stop = $urandom_range(0, 199) < 1;
      bus.temp_ok = $urandom_range(0, 99) < p;
      tick(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hatch_seq.md
HATCH_SEQ -- requirements
Module: hatch_seq

Interface
REQ-001 SHALL have parameter TICKS_PER_STAGE, default 1000: clk cycles per incubation stage (1 s at 1 kHz); legal range 2..65535.
REQ-002 SHALL have parameter LAST_STAGE, default 11: final stage index shown on the dot matrix; legal range 1..14.
REQ-003 SHALL have parameter GOOD_TICKS, default 200: consecutive temp_ok-high cycles required to leave HOLD; legal range 1..65535.
REQ-004 SHALL have parameter FAIL_TICKS, default 5000: maximum cycles spent in HOLD before FAIL; legal range 2..65535.
REQ-005 SHALL have port clk, input, 1 bit: 1 kHz system clock; all state changes occur on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: synchronous, level-sampled command to begin or restart incubation.
REQ-008 SHALL have port stop, input, 1 bit: synchronous, level-sampled abort command.
REQ-009 SHALL have port temp_ok, input, 1 bit: 1 = incubator temperature within band.
REQ-010 SHALL have port num, output, 4 bits: current stage index driven to the matrix display.
REQ-011 SHALL have port st, output, 1 bit: display enable; 0 blanks the display.
REQ-012 SHALL have port temp, output, 1 bit: 1 = temperature alarm, selects the red overlay on the display.
REQ-013 SHALL have port done, output, 1 bit: 1 = hatching complete.
REQ-014 SHALL have port fail, output, 1 bit: 1 = incubation aborted by prolonged temperature fault.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, HOLD, DONE, FAIL; all outputs registered.
REQ-016 SHALL treat stop as highest priority: stop=1 in any state -> IDLE next cycle, regardless of start or temp_ok.
REQ-017 IDLE: num=0, st=0, temp=0, done=0, fail=0; start=1 -> RUN with num=0, tick counter=0.
REQ-018 RUN: st=1, temp=0; tick counter increments each cycle.
REQ-019 RUN: when the tick counter equals TICKS_PER_STAGE-1, it SHALL clear to 0 and num SHALL increment by 1 on the same edge; stage 0 therefore lasts exactly TICKS_PER_STAGE cycles after entry.
REQ-020 RUN: when num increments to LAST_STAGE, the FSM SHALL enter DONE on that same edge.
REQ-021 RUN: temp_ok=0 -> HOLD next cycle; the tick counter and num SHALL freeze; temp_ok=0 on a stage-boundary cycle SHALL suppress that advance.
REQ-022 HOLD: st=1, temp=1, num unchanged; good counter counts consecutive temp_ok=1 cycles and clears on any temp_ok=0.
REQ-023 HOLD: when the good counter reaches GOOD_TICKS, the FSM SHALL return to RUN and the tick counter SHALL resume from its frozen value.
REQ-024 HOLD: a hold counter counts every cycle spent in HOLD, including cycles with temp_ok=1; reaching FAIL_TICKS SHALL enter FAIL; FAIL SHALL take priority over return to RUN when both occur on the same cycle.
REQ-025 A new entry into HOLD SHALL clear both the hold counter and the good counter.
REQ-026 DONE: num=LAST_STAGE, st=1, temp=0, done=1; temp_ok ignored; start=1 -> RUN with num=0 and counters cleared.
REQ-027 FAIL: num=4'd15, st=1, temp=1, fail=1; only stop or start leave FAIL; start -> RUN from num=0.
REQ-028 start=1 while in RUN or HOLD SHALL be ignored.
REQ-029 Counters SHALL be 16 bits wide and SHALL never wrap in any state.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, num=0, st=0, temp=0, done=0, fail=0, and all counters to 0, including mid-RUN and mid-HOLD.
REQ-031 After rst deasserts, the block SHALL remain in IDLE until start=1 is sampled.

Verification
Test parameters: TICKS_PER_STAGE=4, LAST_STAGE=11, GOOD_TICKS=3, FAIL_TICKS=20.
REQ-032 Start with temp_ok=1 held -> num steps 0..11, one step every 4 cycles; done=1 exactly 44 cycles after the start sample; st=1 throughout.
REQ-033 Set temp_ok=0 for 5 cycles at num=3, counter=2 -> temp=1, num stays 3; after 3 good cycles RUN resumes; num becomes 4 exactly 2 cycles later.
REQ-034 Hold temp_ok=0 for 25 cycles in RUN -> fail=1 and num=15 on the 20th HOLD cycle; assert start -> num=0, fail=0, RUN.
REQ-035 Assert start and stop together in RUN at num=5 -> IDLE, num=0, st=0; assert start alone -> RUN from 0.
REQ-036 Pulse rst asynchronously mid-HOLD at num=7 -> outputs 0 immediately, without waiting for a clk edge; no activity until start.
